// File: rtl/audio_codec_config.sv
// audio_codec_config
// Write-only I2C master that brings up a WM8731 codec after reset (11-word init
// table), then serves headphone-volume updates. Each frame carries three bytes:
// device address, word[15:8], word[7:0]. A NACKed word is resent up to MAX_RETRY
// times before it is abandoned and oACK_ERR is raised.
//
// Ports
//   iCLK_18_4  in      system clock
//   iRST_N     in      asynchronous active-low reset
//   iVOL_REQ   in      one-clock request to write iVOLUME to both headphone channels
//   iVOLUME    in [7]  volume code, latched on the iVOL_REQ cycle
//   I2C_SCLK   out     I2C clock, push-pull
//   I2C_SDAT   inout   I2C data, open-drain (0 or Z)
//   oBUSY      out     frame in progress (START through GAP)
//   oDONE      out     init table finished, sticky
//   oACK_ERR   out     some word ran out of retries, sticky
//
// state | meaning
// IDLE  | bus free; on a tick, start next init word, volume retry or pending volume
// START | 4 quarters: SDA=Z,SCL=1 | SDA=0 | SDA=0 | SCL=0
// BIT   | 27 bits (3 x 8 data + ack); q0 SDA, q1 SCL=1, q2 ack sample, q3 SCL=0
// STOP  | 4 quarters: SDA=0 | SCL=1 | SDA=Z | hold
// GAP   | 4 idle quarters for codec bus-free time; ACK bookkeeping on entry
module audio_codec_config #(
  parameter int unsigned REF_CLK   = 18432000,
  parameter int unsigned I2C_CLK   = 20000,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       iCLK_18_4,
  input  logic       iRST_N,
  input  logic       iVOL_REQ,
  input  logic [6:0] iVOLUME,
  output logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oACK_ERR
);

  localparam int unsigned QTR       = REF_CLK / (I2C_CLK * 4);
  localparam int unsigned CW        = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);
  localparam int unsigned RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [3:0] LAST_IDX   = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    pos_q, pos_d;
  logic [23:0]   sh_q, sh_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          nack_q, nack_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          vol_pend_q, vol_pend_d;
  logic [6:0]    vol_q, vol_d;
  logic          vol_act_q, vol_act_d;
  logic          is_vol_q, is_vol_d;
  logic [15:0]   word_q, word_d;

  logic tick;
  logic start;
  logic advance;
  logic sda_in;

  function automatic logic [15:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = 16'h1E00;
      4'd1:    init_word = 16'h001A;
      4'd2:    init_word = 16'h021A;
      4'd3:    init_word = 16'h047B;
      4'd4:    init_word = 16'h067B;
      4'd5:    init_word = 16'h0812;
      4'd6:    init_word = 16'h0A06;
      4'd7:    init_word = 16'h0C00;
      4'd8:    init_word = 16'h0E01;
      4'd9:    init_word = 16'h1002;
      4'd10:   init_word = 16'h1201;
      default: init_word = 16'h1201;
    endcase
  endfunction

  assign tick     = (cnt_q == QTR_LAST);
  assign sda_in   = I2C_SDAT;
  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_q;
  assign oBUSY    = (state_q != S_IDLE);
  assign oDONE    = done_q;
  assign oACK_ERR = err_q;

  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    cnt_d      = cnt_q + CW'(1);
    byte_d     = byte_q;
    pos_d      = pos_q;
    sh_d       = sh_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
    nack_d     = nack_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    done_d     = done_q;
    err_d      = err_q;
    vol_pend_d = vol_pend_q;
    vol_d      = vol_q;
    vol_act_d  = vol_act_q;
    is_vol_d   = is_vol_q;
    word_d     = word_q;
    start      = 1'b0;
    advance    = 1'b0;

    if (tick) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
      unique case (state_q)
        S_IDLE: begin
          qtr_d = 2'd0;
          if (!done_q) begin
            start    = 1'b1;
            word_d   = init_word(idx_q);
            is_vol_d = 1'b0;
          end else if (vol_act_q) begin
            // Retry of a NACKed volume frame reuses the word latched at its first start.
            start    = 1'b1;
            is_vol_d = 1'b1;
          end else if (vol_pend_q) begin
            start      = 1'b1;
            word_d     = {7'h02, 1'b1, 1'b0, vol_q};
            is_vol_d   = 1'b1;
            vol_act_d  = 1'b1;
            vol_pend_d = 1'b0;
          end
          if (start) begin
            state_d  = S_START;
            nack_d   = 1'b0;
            sh_d     = {DEV_ADDR, word_d};
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
          end
        end
        S_START: begin
          unique case (qtr_q)
            2'd0: sda_oe_d = 1'b1;
            2'd1: sda_oe_d = 1'b1;
            2'd2: scl_d    = 1'b0;
            default: begin
              state_d  = S_BIT;
              byte_d   = 2'd0;
              pos_d    = 4'd0;
              sda_oe_d = ~sh_q[23];
              sh_d     = {sh_q[22:0], 1'b0};
            end
          endcase
        end
        S_BIT: begin
          unique case (qtr_q)
            2'd0: scl_d = 1'b1;
            2'd1: scl_d = 1'b1;
            2'd2: begin
              scl_d = 1'b0;
              if (pos_q == 4'd8 && sda_in) nack_d = 1'b1;
            end
            default: begin
              if (byte_q == 2'd2 && pos_q == 4'd8) begin
                state_d  = S_STOP;
                sda_oe_d = 1'b1;
              end else if (pos_q == 4'd8) begin
                pos_d    = 4'd0;
                byte_d   = byte_q + 2'd1;
                sda_oe_d = ~sh_q[23];
                sh_d     = {sh_q[22:0], 1'b0};
              end else if (pos_q == 4'd7) begin
                pos_d    = 4'd8;
                sda_oe_d = 1'b0;
              end else begin
                pos_d    = pos_q + 4'd1;
                sda_oe_d = ~sh_q[23];
                sh_d     = {sh_q[22:0], 1'b0};
              end
            end
          endcase
        end
        S_STOP: begin
          unique case (qtr_q)
            2'd0: scl_d    = 1'b1;
            2'd1: sda_oe_d = 1'b0;
            2'd2: scl_d    = 1'b1;
            default: begin
              state_d = S_GAP;
              if (nack_q) begin
                if (retry_q == RETRY_LIM) begin
                  err_d   = 1'b1;
                  retry_d = '0;
                  advance = 1'b1;
                end else begin
                  retry_d = retry_q + RW'(1);
                end
              end else begin
                retry_d = '0;
                advance = 1'b1;
              end
              if (advance) begin
                if (is_vol_q) begin
                  vol_act_d = 1'b0;
                end else if (idx_q == LAST_IDX) begin
                  done_d = 1'b1;
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
            end
          endcase
        end
        S_GAP: begin
          if (qtr_q == 2'd3) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Placed last so a request coinciding with the pending-clear keeps the new value pending.
    if (iVOL_REQ) begin
      vol_pend_d = 1'b1;
      vol_d      = iVOLUME;
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      qtr_q      <= 2'd0;
      cnt_q      <= '0;
      byte_q     <= 2'd0;
      pos_q      <= 4'd0;
      sh_q       <= '0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      nack_q     <= 1'b0;
      idx_q      <= 4'd0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vol_pend_q <= 1'b0;
      vol_q      <= 7'd0;
      vol_act_q  <= 1'b0;
      is_vol_q   <= 1'b0;
      word_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      pos_q      <= pos_d;
      sh_q       <= sh_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      nack_q     <= nack_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vol_pend_q <= vol_pend_d;
      vol_q      <= vol_d;
      vol_act_q  <= vol_act_d;
      is_vol_q   <= is_vol_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for audio_codec_config: I2C slave/monitor with programmable NACK,
// frame scoreboard, SCL timing and SDA-stability checks.
module tb_audio_codec_config;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       vol_req = 1'b0;
  logic [6:0] volume  = 7'd0;
  logic       scl, busy, done, ack_err;
  wire        sda_w;
  logic       slave_low = 1'b0;

  assign sda_w = slave_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  audio_codec_config #(
    .REF_CLK(18432000), .I2C_CLK(1152000), .DEV_ADDR(8'h34), .MAX_RETRY(3)
  ) dut (
    .iCLK_18_4(clk), .iRST_N(rst_n), .iVOL_REQ(vol_req), .iVOLUME(volume),
    .I2C_SCLK(scl), .I2C_SDAT(sda_w), .oBUSY(busy), .oDONE(done), .oACK_ERR(ack_err)
  );

  int tests  = 0;
  int failed = 0;

  logic [23:0] exp_q[$];
  logic [15:0] init_tbl [11];
  logic [15:0] nack_word = 16'hFFFF;
  int          nack_left = 0;

  // monitor state
  int          frames_seen = 0;
  int          bitcnt      = 0;
  int          prot_err    = 0;
  int          scl_cnt     = 0;
  logic        in_frame    = 1'b0;
  logic        have_edge   = 1'b0;
  logic        prev_scl    = 1'b1;
  logic        prev_sda    = 1'b1;
  logic        scl_now, sda_now;
  logic [26:0] sreg        = '0;
  logic [15:0] word_seen;
  logic [23:0] frame_v;
  int          cyc         = 0;

  typedef struct {
    logic [15:0] nack_word;
    int          nack_times;
    int          exp_frames;
    logic        exp_err;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // I2C slave + monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame    = 1'b0;
      bitcnt      = 0;
      slave_low   = 1'b0;
      frames_seen = 0;
      prot_err    = 0;
      have_edge   = 1'b0;
      scl_cnt     = 0;
      prev_scl    = scl;
      prev_sda    = sda_w;
    end else begin
      scl_now = scl;
      sda_now = sda_w;
      scl_cnt++;
      if (prev_scl && scl_now && (sda_now != prev_sda)) begin
        if (!sda_now && !in_frame) begin
          in_frame  = 1'b1;
          bitcnt    = 0;
          sreg      = '0;
          have_edge = 1'b0;
          prot_err  = 0;
        end else if (sda_now && in_frame && bitcnt == 27) begin
          in_frame = 1'b0;
          frames_seen++;
          frame_v = {sreg[26:19], sreg[17:10], sreg[8:1]};
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL frame_extra: got %06h, want no frame", frame_v);
          end else begin
            check("frame", {8'h00, frame_v}, {8'h00, exp_q.pop_front()});
          end
          check("protocol", prot_err, 0);
        end else begin
          prot_err++;
        end
      end
      if (scl_now != prev_scl) begin
        if (in_frame && have_edge && scl_cnt != 8) prot_err++;
        have_edge = in_frame;
        scl_cnt   = 0;
        if (in_frame) begin
          if (scl_now) begin
            if (bitcnt < 27) begin
              sreg = {sreg[25:0], sda_now};
              bitcnt++;
            end
          end else begin
            if (bitcnt == 8 || bitcnt == 17) begin
              slave_low = 1'b1;
            end else if (bitcnt == 26) begin
              word_seen = {sreg[16:9], sreg[7:0]};
              if (word_seen == nack_word && nack_left > 0) begin
                nack_left--;
                slave_low = 1'b0;
              end else begin
                slave_low = 1'b1;
              end
            end else if (bitcnt == 9 || bitcnt == 18 || bitcnt == 27) begin
              slave_low = 1'b0;
            end
          end
        end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
    end
  end

  task automatic do_reset(input logic [15:0] nw, input int nt);
    @(negedge clk);
    rst_n   = 1'b0;
    vol_req = 1'b0;
    repeat (3) @(negedge clk);
    nack_word = nw;
    nack_left = nt;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic push_init();
    for (int i = 0; i < 11; i++) exp_q.push_back({8'h34, init_tbl[i]});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check(name, {31'd0, done}, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check(name, {31'd0, busy}, 0);
  endtask

  task automatic wait_frames(input int cnt, input int budget, input string name);
    int n = 0;
    while (frames_seen < cnt && n < budget) begin @(negedge clk); n++; end
    check(name, {31'd0, frames_seen >= cnt}, 1);
  endtask

  task automatic pulse_vol(input logic [6:0] v);
    vol_req = 1'b1;
    volume  = v;
    @(negedge clk);
    vol_req = 1'b0;
  endtask

  initial begin
    int n;
    int nk;
    int att;
    init_tbl = '{16'h1E00, 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h0812,
                 16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};
    vecs[0] = '{16'hFFFF, 0, 11, 1'b0};
    vecs[1] = '{16'h047B, 4, 14, 1'b1};
    vecs[2] = '{16'h047B, 3, 14, 1'b0};
    vecs[3] = '{16'h1201, 5, 14, 1'b1};

    // reset values
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_scl", {31'd0, scl}, 1);
    check("rst_sda", {31'd0, sda_w}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, ack_err}, 0);

    // init runs with various NACK patterns
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].nack_word, vecs[v].nack_times);
      for (int i = 0; i < 11; i++) begin
        nk  = (init_tbl[i] == vecs[v].nack_word) ? vecs[v].nack_times : 0;
        att = (nk > 3) ? 4 : nk + 1;
        for (int k = 0; k < att; k++) exp_q.push_back({8'h34, init_tbl[i]});
      end
      wait_done(12000, "init_done_wait");
      wait_idle(200, "init_idle_wait");
      check("init_frames", frames_seen, vecs[v].exp_frames);
      check("init_err", {31'd0, ack_err}, {31'd0, vecs[v].exp_err});
      check("init_done", {31'd0, done}, 1);
      check("init_queue_left", exp_q.size(), 0);
    end

    // volume request during init is deferred until after the 11th init frame
    do_reset(16'hFFFF, 0);
    push_init();
    wait_frames(3, 3000, "t3_wait3");
    @(negedge clk);
    exp_q.push_back(24'h340555);
    pulse_vol(7'h55);
    wait_frames(12, 8000, "t3_wait12");
    wait_idle(200, "t3_idle");
    check("t3_queue_left", exp_q.size(), 0);
    check("t3_done", {31'd0, done}, 1);
    check("t3_frames", frames_seen, 12);

    // two requests before service: only the last value is written
    do_reset(16'hFFFF, 0);
    push_init();
    wait_done(12000, "t4_done_wait");
    exp_q.push_back(24'h34057F);
    pulse_vol(7'h30);
    @(negedge clk);
    pulse_vol(7'h7F);
    wait_frames(12, 2000, "t4_wait12");
    wait_idle(200, "t4_idle");
    check("t4_frames", frames_seen, 12);

    // request landing on the exact tick that starts the previous request's frame
    n = 0;
    while ((cyc % 4) != 1 && n < 8) begin @(negedge clk); n++; end
    exp_q.push_back(24'h340511);
    exp_q.push_back(24'h340522);
    pulse_vol(7'h11);   // sampled at cyc%4==2
    vol_req = 1'b0;
    @(negedge clk);     // now cyc%4==3
    pulse_vol(7'h22);   // sampled on the tick edge
    wait_frames(14, 2000, "t4b_wait14");
    wait_idle(200, "t4b_idle");
    check("t4b_frames", frames_seen, 14);
    check("t4b_queue_left", exp_q.size(), 0);

    // reset in the middle of frame 5
    do_reset(16'hFFFF, 0);
    push_init();
    n = 0;
    while (!(frames_seen == 4 && in_frame && bitcnt == 13 && scl == 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached", {31'd0, (frames_seen == 4 && bitcnt == 13)}, 1);
    rst_n = 1'b0;
    #1;
    check("t5_scl", {31'd0, scl}, 1);
    check("t5_sda", {31'd0, sda_w}, 1);
    check("t5_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    push_init();
    rst_n = 1'b1;
    wait_done(12000, "t5_done_wait");
    wait_idle(200, "t5_idle");
    check("t5_frames", frames_seen, 11);
    check("t5_queue_left", exp_q.size(), 0);
    check("t5_err", {31'd0, ack_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
